// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: UART transmit framer.
// A Send/Busy handshake latches one byte and its line configuration. The block
// then drives start, 7/8 data bits LSB-first, optional parity and 1/2 stop bits
// onto TxOut. Each of these bits lasts one baud tick period.
`timescale 1ns/1ps
module uart_tx_sequencer (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       BaudTick,
  input  logic       Send,
  input  logic [7:0] DataIn,
  input  logic [1:0] ParityType,
  input  logic       StopBits,
  input  logic       DataLength,
  output logic       TxOut,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_e;

  // Parity over the active data bits: even -> XOR-reduce, odd -> inverted.
  // Codes 00 and 11 carry no parity bit, so the value there is irrelevant.
  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic       len8,
                                       input logic [1:0] ptype);
    logic x;
    x = len8 ? (^data) : (^data[6:0]);
    case (ptype)
      2'b01:   calc_parity = ~x;
      2'b10:   calc_parity = x;
      default: calc_parity = 1'b0;
    endcase
  endfunction

  // A parity bit is transmitted only for the odd and even codes.
  function automatic logic parity_enabled(input logic [1:0] ptype);
    parity_enabled = (ptype == 2'b01) || (ptype == 2'b10);
  endfunction

  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       par_en_q, par_en_d;
  logic       par_bit_q, par_bit_d;
  logic       two_stop_q, two_stop_d;
  logic       len8_q, len8_d;
  logic [2:0] idx_q, idx_d;
  logic       stop_q, stop_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [2:0] last_idx_s;
  logic [2:0] next_idx_s;

  assign last_idx_s = len8_q ? 3'd7 : 3'd6;
  assign next_idx_s = idx_q + 3'd1;

  // Next-state and next-output logic; every transition out of a non-idle state
  // waits for a baud tick so each line bit lasts exactly one tick period.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    len8_d     = len8_q;
    idx_d      = idx_q;
    stop_d     = stop_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (Send) begin
          data_d     = DataIn;
          len8_d     = DataLength;
          two_stop_d = StopBits;
          par_en_d   = parity_enabled(ParityType);
          par_bit_d  = calc_parity(DataIn, DataLength, ParityType);
          idx_d      = 3'd0;
          stop_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_SYNC;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_SYNC: begin
        // The tick that coincides with acceptance is never seen here.
        if (BaudTick) begin
          tx_d    = 1'b0;
          state_d = ST_START;
        end else begin
          state_d = ST_SYNC;
        end
      end

      ST_START: begin
        if (BaudTick) begin
          tx_d    = data_q[0];
          idx_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end

      ST_DATA: begin
        if (BaudTick) begin
          if (idx_q != last_idx_s) begin
            tx_d  = data_q[next_idx_s];
            idx_d = next_idx_s;
          end else if (par_en_q) begin
            tx_d    = par_bit_q;
            state_d = ST_PARITY;
          end else begin
            tx_d    = 1'b1;
            stop_d  = 1'b0;
            state_d = ST_STOP;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_PARITY: begin
        if (BaudTick) begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end

      ST_STOP: begin
        if (BaudTick) begin
          if (two_stop_q && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            // Busy drops in the same cycle Done is raised.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      data_q     <= 8'h00;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      len8_q     <= 1'b0;
      idx_q      <= 3'd0;
      stop_q     <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      len8_q     <= len8_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign TxOut = tx_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule
